// File: rtl/pipe_stage_skid.sv
// EX->MEM pipeline stage with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int BIT_WIDTH  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID_EN    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BIT_WIDTH-1:0]  i_pc,
    input  logic [BIT_WIDTH-1:0]  i_alu,
    input  logic [BIT_WIDTH-1:0]  i_r2_d,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_we,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [BIT_WIDTH-1:0]  o_pc,
    output logic [BIT_WIDTH-1:0]  o_alu,
    output logic [BIT_WIDTH-1:0]  o_r2_d,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_we,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    typedef struct packed {
        logic [BIT_WIDTH-1:0]  pc;
        logic [BIT_WIDTH-1:0]  alu;
        logic [BIT_WIDTH-1:0]  r2_d;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
    } entry_t;

    // EMPTY: no entry, BUSY: main slot holds one, FULL: main + skid both held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             valid;
    logic             ready;
    logic             accept;
    logic             emit;

    assign in_entry = '{pc: i_pc, alu: i_alu, r2_d: i_r2_d, rd: i_rd, we: i_we};
    assign accept   = i_valid && ready;
    assign emit     = valid && i_ready;

    // NOTE: sequential state is only ever assigned with <= so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = BUSY;
                BUSY: begin
                    if (accept && !emit)      state_d = FULL;
                    else if (!accept && emit) state_d = EMPTY;
                end
                FULL:    if (emit) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Skid mode decodes o_ready from state only, cutting the i_ready -> o_ready path.
    always_comb begin
        valid = (state_q != EMPTY);
        if (SKID_EN != 0) ready = (state_q != FULL);
        else              ready = !valid || i_ready;
    end

    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (i_flush) begin
            main_d.we = 1'b0;
            skid_d.we = 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (accept) main_d = in_entry;
                BUSY: begin
                    if (accept && emit) main_d = in_entry;
                    else if (accept)    skid_d = in_entry;
                end
                FULL:    if (emit) main_d = skid_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid && !i_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign o_valid     = valid;
    assign o_ready     = ready;
    assign o_pc        = main_q.pc;
    assign o_alu       = main_q.alu;
    assign o_r2_d      = main_q.r2_d;
    assign o_rd        = main_q.rd;
    assign o_we        = main_q.we && valid;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: dut_a is the skid variant with a 4-bit counter,
// dut_b the single-slot variant; both are checked against a FIFO queue model.
module tb_pipe_stage_skid;

    localparam int BW   = 32;
    localparam int RW   = 5;
    localparam int CW_A = 4;
    localparam int CW_B = 16;

    typedef struct packed {
        logic [BW-1:0] pc;
        logic [BW-1:0] alu;
        logic [BW-1:0] r2;
        logic [RW-1:0] rd;
        logic          we;
    } ent_t;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_flush = 1'b0;
    logic [BW-1:0] i_pc = '0, i_alu = '0, i_r2_d = '0;
    logic [RW-1:0] i_rd = '0;
    logic          i_we = 1'b0;

    logic a_i_valid = 1'b0, a_i_ready = 1'b0, a_o_ready, a_o_valid, a_o_we;
    logic [BW-1:0] a_o_pc, a_o_alu, a_o_r2_d;
    logic [RW-1:0] a_o_rd;
    logic [CW_A-1:0] a_o_stall_cnt;

    logic b_i_valid = 1'b0, b_i_ready = 1'b0, b_o_ready, b_o_valid, b_o_we;
    logic [BW-1:0] b_o_pc, b_o_alu, b_o_r2_d;
    logic [RW-1:0] b_o_rd;
    logic [CW_B-1:0] b_o_stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    pipe_stage_skid #(.BIT_WIDTH(BW), .REG_ADDR_W(RW), .SKID_EN(1), .CNT_W(CW_A)) dut_a (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .i_valid(a_i_valid), .o_ready(a_o_ready),
        .i_pc(i_pc), .i_alu(i_alu), .i_r2_d(i_r2_d), .i_rd(i_rd), .i_we(i_we),
        .o_valid(a_o_valid), .i_ready(a_i_ready),
        .o_pc(a_o_pc), .o_alu(a_o_alu), .o_r2_d(a_o_r2_d), .o_rd(a_o_rd), .o_we(a_o_we),
        .o_stall_cnt(a_o_stall_cnt)
    );

    pipe_stage_skid #(.BIT_WIDTH(BW), .REG_ADDR_W(RW), .SKID_EN(0), .CNT_W(CW_B)) dut_b (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
        .i_valid(b_i_valid), .o_ready(b_o_ready),
        .i_pc(i_pc), .i_alu(i_alu), .i_r2_d(i_r2_d), .i_rd(i_rd), .i_we(i_we),
        .o_valid(b_o_valid), .i_ready(b_i_ready),
        .o_pc(b_o_pc), .o_alu(b_o_alu), .o_r2_d(b_o_r2_d), .o_rd(b_o_rd), .o_we(b_o_we),
        .o_stall_cnt(b_o_stall_cnt)
    );

    task automatic drive_a(input logic v, input logic [BW-1:0] pc, input logic [BW-1:0] alu,
                           input logic [RW-1:0] rd, input logic we);
        a_i_valid = v;
        i_pc      = pc;
        i_alu     = alu;
        i_r2_d    = pc ^ alu;
        i_rd      = rd;
        i_we      = we;
    endtask

    // Reset pulse placed mid-cycle; returns at the first negedge after one clean edge.
    task automatic do_reset();
        @(negedge i_clk);
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        i_flush   = 1'b0;
        i_rstn    = 1'b0;
        #2;
        i_rstn = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", a_o_valid); else n_pass++;
        n_checks++; if (a_o_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", a_o_we); else n_pass++;
        n_checks++; if (a_o_rd !== '0) $display("FAIL reset_rd: got %0d want 0", a_o_rd); else n_pass++;
        n_checks++; if (a_o_stall_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", a_o_stall_cnt); else n_pass++;
        n_checks++; if (b_o_valid !== 1'b0) $display("FAIL reset_b_valid: got %0b want 0", b_o_valid); else n_pass++;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        n_checks++; if (a_o_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", a_o_ready); else n_pass++;
        n_checks++; if (b_o_ready !== 1'b1) $display("FAIL reset_b_ready: got %0b want 1", b_o_ready); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [BW-1:0] pcs  [3];
        logic [BW-1:0] alus [3];
        pcs  = '{32'h0, 32'h4, 32'h8};
        alus = '{32'h11, 32'h22, 32'h33};
        do_reset();
        a_i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                n_checks++; if (a_o_valid !== 1'b1) $display("FAIL stream_valid%0d: got %0b want 1", k, a_o_valid); else n_pass++;
                n_checks++; if (a_o_pc !== pcs[k-1]) $display("FAIL stream_pc%0d: got %h want %h", k, a_o_pc, pcs[k-1]); else n_pass++;
                n_checks++; if (a_o_alu !== alus[k-1]) $display("FAIL stream_alu%0d: got %h want %h", k, a_o_alu, alus[k-1]); else n_pass++;
            end
            if (k < 3) drive_a(1'b1, pcs[k], alus[k], RW'(k + 1), 1'b1);
            else       a_i_valid = 1'b0;
            @(negedge i_clk);
        end
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL stream_drain: got %0b want 0", a_o_valid); else n_pass++;
        n_checks++; if (a_o_stall_cnt !== '0) $display("FAIL stream_cnt: got %0d want 0", a_o_stall_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        a_i_ready = 1'b0;
        drive_a(1'b1, 32'h100, 32'ha1, 5'd1, 1'b1);
        @(negedge i_clk);
        n_checks++; if (a_o_pc !== 32'h100) $display("FAIL bp_first_pc: got %h want 100", a_o_pc); else n_pass++;
        n_checks++; if (a_o_ready !== 1'b1) $display("FAIL bp_ready_busy: got %0b want 1", a_o_ready); else n_pass++;
        drive_a(1'b1, 32'h104, 32'ha2, 5'd2, 1'b1);
        @(negedge i_clk);
        a_i_valid = 1'b0;
        n_checks++; if (a_o_ready !== 1'b0) $display("FAIL bp_ready_full: got %0b want 0", a_o_ready); else n_pass++;
        n_checks++; if (a_o_pc !== 32'h100) $display("FAIL bp_hold_pc: got %h want 100", a_o_pc); else n_pass++;
        @(negedge i_clk);
        n_checks++; if (a_o_pc !== 32'h100) $display("FAIL bp_hold_pc2: got %h want 100", a_o_pc); else n_pass++;
        n_checks++; if (a_o_stall_cnt !== 4'd2) $display("FAIL bp_cnt: got %0d want 2", a_o_stall_cnt); else n_pass++;
        a_i_ready = 1'b1;
        @(negedge i_clk);
        n_checks++; if (a_o_pc !== 32'h104 || a_o_valid !== 1'b1) $display("FAIL bp_second: got pc=%h v=%0b want pc=104 v=1", a_o_pc, a_o_valid); else n_pass++;
        n_checks++; if (a_o_ready !== 1'b1) $display("FAIL bp_ready_back: got %0b want 1", a_o_ready); else n_pass++;
        @(negedge i_clk);
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL bp_no_dup: got %0b want 0", a_o_valid); else n_pass++;
        n_checks++; if (a_o_stall_cnt !== 4'd2) $display("FAIL bp_cnt_final: got %0d want 2", a_o_stall_cnt); else n_pass++;
    endtask

    task automatic test_flush_full();
        do_reset();
        a_i_ready = 1'b0;
        drive_a(1'b1, 32'h300, 32'h5, 5'd5, 1'b1);
        @(negedge i_clk);
        drive_a(1'b1, 32'h304, 32'h6, 5'd6, 1'b1);
        @(negedge i_clk);
        n_checks++; if (a_o_ready !== 1'b0) $display("FAIL flush_pre_ready: got %0b want 0", a_o_ready); else n_pass++;
        n_checks++; if (a_o_rd !== 5'd5 || a_o_we !== 1'b1) $display("FAIL flush_pre_head: got rd=%0d we=%0b want rd=5 we=1", a_o_rd, a_o_we); else n_pass++;
        drive_a(1'b1, 32'h200, 32'h7, 5'd7, 1'b1);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush   = 1'b0;
        a_i_valid = 1'b0;
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", a_o_valid); else n_pass++;
        n_checks++; if (a_o_we !== 1'b0) $display("FAIL flush_we: got %0b want 0", a_o_we); else n_pass++;
        n_checks++; if (a_o_ready !== 1'b1) $display("FAIL flush_ready: got %0b want 1", a_o_ready); else n_pass++;
        a_i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            n_checks++; if (a_o_valid !== 1'b0) $display("FAIL flush_stays_empty%0d: got %0b want 0", k, a_o_valid); else n_pass++;
        end
        // Flush while empty and ready: the offered entry must be dropped.
        drive_a(1'b1, 32'h208, 32'h8, 5'd8, 1'b1);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush   = 1'b0;
        a_i_valid = 1'b0;
        n_checks++; if (a_o_valid !== 1'b0) $display("FAIL flush_drop_offer: got %0b want 0", a_o_valid); else n_pass++;
    endtask

    task automatic test_bubble_gating();
        do_reset();
        a_i_ready = 1'b1;
        drive_a(1'b0, 32'h500, 32'h0, 5'd7, 1'b1);
        @(negedge i_clk);
        n_checks++; if (a_o_we !== 1'b0) $display("FAIL bubble_we: got %0b want 0", a_o_we); else n_pass++;
        drive_a(1'b1, 32'h504, 32'h0, 5'd7, 1'b1);
        @(negedge i_clk);
        a_i_valid = 1'b0;
        n_checks++; if (a_o_we !== 1'b1 || a_o_rd !== 5'd7) $display("FAIL bubble_real: got we=%0b rd=%0d want we=1 rd=7", a_o_we, a_o_rd); else n_pass++;
        @(negedge i_clk);
        n_checks++; if (a_o_we !== 1'b0) $display("FAIL bubble_one_cycle: got %0b want 0", a_o_we); else n_pass++;
    endtask

    task automatic test_counter_sat();
        do_reset();
        a_i_ready = 1'b0;
        drive_a(1'b1, 32'h600, 32'h66, 5'd9, 1'b1);
        @(negedge i_clk);
        a_i_valid = 1'b0;
        repeat (20) @(negedge i_clk);
        n_checks++; if (a_o_stall_cnt !== 4'd15) $display("FAIL sat_cnt: got %0d want 15", a_o_stall_cnt); else n_pass++;
        @(negedge i_clk);
        n_checks++; if (a_o_stall_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", a_o_stall_cnt); else n_pass++;
        #2;
        i_rstn = 1'b0;
        #1;
        n_checks++; if (a_o_valid !== 1'b0 || a_o_we !== 1'b0) $display("FAIL arst_flags: got v=%0b we=%0b want 0 0", a_o_valid, a_o_we); else n_pass++;
        n_checks++; if ({a_o_pc, a_o_alu, a_o_r2_d, a_o_rd} !== '0) $display("FAIL arst_data: got pc=%h alu=%h r2=%h rd=%0d want all 0", a_o_pc, a_o_alu, a_o_r2_d, a_o_rd); else n_pass++;
        n_checks++; if (a_o_stall_cnt !== '0) $display("FAIL arst_cnt: got %0d want 0", a_o_stall_cnt); else n_pass++;
        #1;
        i_rstn = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_no_skid();
        do_reset();
        b_i_ready = 1'b0;
        b_i_valid = 1'b1;
        i_pc      = 32'h400;
        #1;
        n_checks++; if (b_o_ready !== 1'b1) $display("FAIL ns_ready_empty: got %0b want 1", b_o_ready); else n_pass++;
        @(negedge i_clk);
        i_pc = 32'h404;
        #1;
        n_checks++; if (b_o_ready !== 1'b0) $display("FAIL ns_ready_stall: got %0b want 0", b_o_ready); else n_pass++;
        n_checks++; if (b_o_pc !== 32'h400) $display("FAIL ns_pc_first: got %h want 400", b_o_pc); else n_pass++;
        b_i_ready = 1'b1;
        #1;
        n_checks++; if (b_o_ready !== 1'b1) $display("FAIL ns_ready_comb: got %0b want 1", b_o_ready); else n_pass++;
        @(negedge i_clk);
        b_i_valid = 1'b0;
        n_checks++; if (b_o_pc !== 32'h404 || b_o_valid !== 1'b1) $display("FAIL ns_replace: got pc=%h v=%0b want pc=404 v=1", b_o_pc, b_o_valid); else n_pass++;
        @(negedge i_clk);
        n_checks++; if (b_o_valid !== 1'b0) $display("FAIL ns_drain: got %0b want 0", b_o_valid); else n_pass++;
    endtask

    // Random traffic against a queue model: capacity 2 (skid) or 1 (no skid).
    task automatic test_random(input bit use_b, input int n_cycles);
        ent_t q[$];
        ent_t offer;
        int   cnt_m;
        int   cnt_max;
        bit   holding;
        logic v, rdy, fl, exp_valid, exp_ready, exp_we, acc, em;
        logic ov, ordy, owe;
        ent_t obs;
        int   ocnt;
        cnt_m   = 0;
        cnt_max = use_b ? 65535 : 15;
        holding = 1'b0;
        v       = 1'b0;
        offer   = '0;
        do_reset();
        for (int c = 0; c < n_cycles; c++) begin
            if (!holding) begin
                v     = ($urandom_range(0, 9) < 7);
                offer = '{pc: $urandom, alu: $urandom, r2: $urandom, rd: RW'($urandom), we: 1'($urandom)};
            end
            rdy     = ($urandom_range(0, 9) < 6);
            fl      = ($urandom_range(0, 19) == 0);
            i_flush = fl;
            i_pc    = offer.pc;
            i_alu   = offer.alu;
            i_r2_d  = offer.r2;
            i_rd    = offer.rd;
            i_we    = offer.we;
            if (use_b) begin b_i_valid = v; b_i_ready = rdy; end
            else       begin a_i_valid = v; a_i_ready = rdy; end
            #1;
            ov   = use_b ? b_o_valid : a_o_valid;
            ordy = use_b ? b_o_ready : a_o_ready;
            owe  = use_b ? b_o_we : a_o_we;
            obs  = use_b ? '{b_o_pc, b_o_alu, b_o_r2_d, b_o_rd, b_o_we}
                         : '{a_o_pc, a_o_alu, a_o_r2_d, a_o_rd, a_o_we};
            ocnt = use_b ? int'(b_o_stall_cnt) : int'(a_o_stall_cnt);

            exp_valid = (q.size() != 0);
            exp_ready = use_b ? (q.size() == 0 || rdy) : (q.size() < 2);
            exp_we    = exp_valid ? q[0].we : 1'b0;
            n_checks++; if (ov !== exp_valid) $display("FAIL rnd%0d_valid c%0d: got %0b want %0b", use_b, c, ov, exp_valid); else n_pass++;
            n_checks++; if (ordy !== exp_ready) $display("FAIL rnd%0d_ready c%0d: got %0b want %0b", use_b, c, ordy, exp_ready); else n_pass++;
            n_checks++; if (owe !== exp_we) $display("FAIL rnd%0d_we c%0d: got %0b want %0b", use_b, c, owe, exp_we); else n_pass++;
            n_checks++; if (ocnt != cnt_m) $display("FAIL rnd%0d_cnt c%0d: got %0d want %0d", use_b, c, ocnt, cnt_m); else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (obs !== q[0]) $display("FAIL rnd%0d_data c%0d: got %h want %h", use_b, c, obs, q[0]);
                else n_pass++;
            end

            acc = v && exp_ready;
            em  = exp_valid && rdy;
            @(posedge i_clk);
            if (exp_valid && !rdy && cnt_m < cnt_max) cnt_m++;
            if (fl) begin
                q.delete();
            end else begin
                if (em)  void'(q.pop_front());
                if (acc) q.push_back(offer);
            end
            holding = v && !acc && !fl;
            @(negedge i_clk);
        end
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        i_flush   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_bubble_gating();
        test_counter_sat();
        test_no_skid();
        test_random(1'b0, 400);
        test_random(1'b1, 400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised execute→memory pipeline stage for the RV32I core. Carries pc, ALU result, rs2 data, rd index and register-write enable.
- Adds what a plain flop stage lacks: valid/ready handshake, optional 2-entry skid buffer (breaks the combinational ready path), synchronous flush, and a saturating stall-cycle counter.
- Sits between the EX ALU and the MEM/writeback logic. Downstream back-pressure (e.g. data-memory wait) stalls EX without loss or duplication.

Parameters:
- BIT_WIDTH, 32, width of pc/alu/r2_d fields.
- REG_ADDR_W, 5, width of rd field.
- SKID_EN, 1, 1 = two-entry skid buffer with registered o_ready; 0 = single slot with combinational o_ready.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous kill of all held entries (branch/jump redirect)
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry this cycle
- i_pc  in  BIT_WIDTH  instruction pc
- i_alu  in  BIT_WIDTH  ALU result
- i_r2_d  in  BIT_WIDTH  rs2 data (store data)
- i_rd  in  REG_ADDR_W  destination register
- i_we  in  1  register-file write enable
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts
- o_pc  out  BIT_WIDTH  held pc
- o_alu  out  BIT_WIDTH  held ALU result
- o_r2_d  out  BIT_WIDTH  held rs2 data
- o_rd  out  REG_ADDR_W  held rd
- o_we  out  1  write enable, always 0 when o_valid=0
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_valid && !i_ready

Behaviour:
- Reset (async, i_rstn=0):
  - main and skid slots invalid; all data fields 0.
  - o_valid=0, o_we=0, o_rd=0, o_stall_cnt=0.
  - o_ready=1 from the cycle after release.
- Transfer rules:
  - accept = i_valid && o_ready.
  - emit = o_valid && i_ready.
  - Both are evaluated on the same edge.
- Data rules:
  - Data moves only on accept or emit; held fields never change while o_valid && !i_ready.
  - o_we = we_q && valid_q, so a bubble never writes.
- SKID_EN=1 states (main slot drives outputs; o_ready = !skid_valid, registered):
  - EMPTY:
    - accept → main, go BUSY.
  - BUSY:
    - accept && emit → new entry into main, stay BUSY.
    - accept && !emit → entry into skid, go FULL (o_ready drops next cycle).
    - !accept && emit → EMPTY.
    - neither → hold.
  - FULL:
    - o_ready=0, so no accept.
    - emit → skid moves to main, go BUSY.
    - else hold.
  - Ordering: strict FIFO. Main is always older than skid.
- SKID_EN=0:
  - Single slot; o_ready = !o_valid || i_ready (combinational).
  - Accept loads the slot; emit without accept clears valid.
- Throughput:
  - One entry per cycle when i_ready stays 1.
  - Latency 1 cycle: input accepted at edge N appears on outputs after edge N.
- Flush (i_flush=1 at an edge):
  - Both slots invalidated; state → EMPTY; we_q cleared.
  - An entry offered in the same cycle is dropped, not stored.
  - Data fields may retain stale values but o_valid=0 and o_we=0.
  - Flush has priority over accept and emit. An entry emitted in the flush cycle still counts as taken by downstream on that edge.
- Stall counter:
  - Increments each edge where o_valid && !i_ready.
  - Saturates at 2^CNT_W−1; not cleared by flush; cleared only by reset.
- Reset mid-operation: all held entries lost immediately (asynchronous); no partial output.
- Simultaneous i_valid=1 with o_ready=0: the upstream must hold its values. Stage ignores the input.

Test Plan:
- Streaming: reset, i_ready=1, feed pc=0x0,0x4,0x8 on consecutive cycles with alu=0x11,0x22,0x33 → o_valid each following cycle, outputs in same order, o_stall_cnt stays 0.
- Back-pressure fill (SKID_EN=1): i_ready=0, send pc=0x100 then 0x104 → o_ready=0 after 2nd accept, o_pc=0x100 held. Raise i_ready → 0x100 then 0x104 emitted, no loss or duplication, o_stall_cnt=2 or more, o_ready=1 again.
- Flush while FULL: hold two entries with rd=5 and rd=6, we=1, pulse i_flush with i_valid=1 pc=0x200 → next cycle o_valid=0, o_we=0, o_ready=1. 0x200 never appears.
- Bubble gating: i_valid=0 with i_we=1, rd=7 → o_we stays 0. Then valid entry rd=7 we=1 → o_we=1, o_rd=7 for exactly one cycle when i_ready=1.
- Counter saturation (CNT_W=4): hold o_valid=1, i_ready=0 for 20 cycles → o_stall_cnt=15 and holds. Async reset mid-stall → all outputs 0 immediately, o_stall_cnt=0.
- SKID_EN=0: o_valid=1, i_ready=0 → o_ready=0 in the same cycle. Set i_ready=1 with i_valid=1 → o_ready=1 combinationally, new entry replaces old in a single edge.
